// File: rtl/fanout_broadcast_buffer_pkg.sv
// fanout_broadcast_buffer_pkg: defaults and mask type shared by the fanout logic
package fanout_broadcast_buffer_pkg;
  localparam int FANOUT_NUM_OUT_DEFAULT = 20;
  localparam int FANOUT_WIDTH_DEFAULT = 17;
  typedef logic [FANOUT_NUM_OUT_DEFAULT-1:0] fanout_mask_t;
endpackage

// File: rtl/reg_fifo_d2.sv
// reg_fifo_d2: two-entry register FIFO, head always in head_q
module reg_fifo_d2
  import fanout_broadcast_buffer_pkg::*;
#(
  parameter int WIDTH = FANOUT_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic push_ok, pop_ok;
  assign dout = head_q;
  assign count = count_q;
  assign full = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  // next head/tail/count; a pop shifts the tail forward or takes the incoming word
  always_comb begin
    push_ok = push & ~full;
    pop_ok = pop & ~empty;
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    head_d = pop_ok ? (count_q == 2'd2 ? tail_q : din) : ((push_ok && count_q == 2'd0) ? din : head_q);
    tail_d = (push_ok && !pop_ok && count_q == 2'd1) ? din : tail_q;
  end
  // storage registers, flushed on reset
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      count_q <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      count_q <= count_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: rtl/fanout_broadcast_buffer.sv
// fanout_broadcast_buffer: registered broadcast stage with per-consumer acceptance tracking
module fanout_broadcast_buffer
  import fanout_broadcast_buffer_pkg::*;
#(
  parameter int NUM_OUT = FANOUT_NUM_OUT_DEFAULT,
  parameter int WIDTH = FANOUT_WIDTH_DEFAULT
) (
  input  logic               CLK,
  input  logic               ASYNCRESET,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [NUM_OUT-1:0] en,
  input  logic [NUM_OUT-1:0] cfg_mask,
  output logic [WIDTH-1:0]   data_out,
  output logic [NUM_OUT-1:0] valid_out,
  input  logic [NUM_OUT-1:0] ready_in,
  output logic               busy
);
  logic [NUM_OUT-1:0] active, pending_q, pending_d, done_next, accept;
  logic [1:0] count;
  logic push, pop, full, empty;
  assign ready_out = ~full;
  assign busy = (count != 2'd0);
  assign push = valid_in & ready_out;
  reg_fifo_d2 #(.WIDTH(WIDTH)) u_fifo (
    .CLK(CLK),
    .ASYNCRESET(ASYNCRESET),
    .push(push),
    .pop(pop),
    .din(data_in),
    .dout(data_out),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // valid gating and pop once every active consumer has taken the head
  always_comb begin
    active = en & cfg_mask;
    valid_out = {NUM_OUT{~empty}} & active & pending_q;
    done_next = ~active | ~pending_q | ready_in;
    pop = ~empty & (&done_next);
    accept = valid_out & ready_in;
    pending_d = pop ? '1 : pending_q & ~accept;
  end
  // owed-acceptance bits for the current head word
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) pending_q <= '1;
    else pending_q <= pending_d;
  end
endmodule

// File: tb/tb_fanout_broadcast_buffer.sv
// tb_fanout_broadcast_buffer: directed and random checks against a queue-based delivery model
module tb_fanout_broadcast_buffer;
  localparam int N = 4;
  localparam int W = 17;
  logic CLK = 1'b0, ASYNCRESET;
  logic [W-1:0] data_in, data_out;
  logic valid_in, ready_out, busy;
  logic [N-1:0] en, cfg_mask, valid_out, ready_in;
  int tests = 0, fails = 0;
  logic [W-1:0] q[$];
  logic [N-1:0] got = '0, act_m, ev, acc;
  int sz;

  fanout_broadcast_buffer #(.NUM_OUT(N), .WIDTH(W)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .en(en), .cfg_mask(cfg_mask), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  always @(negedge CLK) begin
    if (ASYNCRESET) begin
      q.delete();
      got = '0;
    end else begin
      act_m = en & cfg_mask;
      sz = q.size();
      ev = (sz != 0) ? (act_m & ~got) : '0;
      chk("m_valid", 32'(valid_out), 32'(ev));
      chk("m_busy", 32'(busy), 32'(sz != 0));
      chk("m_ready", 32'(ready_out), 32'(sz < 2));
      if (sz != 0) chk("m_data", 32'(data_out), 32'(q[0]));
      acc = ev & ready_in;
      got = got | acc;
      if (sz != 0 && (got | ~act_m) == '1) begin
        void'(q.pop_front());
        got = '0;
      end
      if (valid_in && sz < 2) q.push_back(data_in);
    end
  end

  initial begin
    ASYNCRESET = 1'b1;
    data_in = '0; valid_in = 1'b0; en = '0; cfg_mask = '0; ready_in = '0;
    #3;
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready_out), 1);
    step();
    ASYNCRESET = 1'b0;
    #1 chk("rel_busy", 32'(busy), 0);
    // basic broadcast
    step();
    en = 4'b1011; cfg_mask = 4'hF; ready_in = 4'hF; valid_in = 1'b1; data_in = 17'h00A5;
    step();
    valid_in = 1'b0;
    #1 chk("bc_valid", 32'(valid_out), 32'h0000000B);
    chk("bc_data", 32'(data_out), 32'h000000A5);
    step();
    #1 chk("bc_busy", 32'(busy), 0);
    // staggered acceptance; bit 0 stays ready after its accept
    step();
    en = 4'b0111; ready_in = 4'b0000; valid_in = 1'b1; data_in = 17'h1234;
    step();
    valid_in = 1'b0; ready_in = 4'b0001;
    #1 chk("st_c1", 32'(valid_out), 32'h7);
    step();
    #1 chk("st_c2", 32'(valid_out), 32'h6);
    step();
    ready_in = 4'b0101;
    #1 chk("st_c3", 32'(valid_out), 32'h6);
    step();
    ready_in = 4'b0001;
    #1 chk("st_c4", 32'(valid_out), 32'h2);
    step();
    ready_in = 4'b0011;
    #1 chk("st_c5", 32'(valid_out), 32'h2);
    chk("st_c5_busy", 32'(busy), 1);
    step();
    #1 chk("st_c6_busy", 32'(busy), 0);
    chk("st_c6_valid", 32'(valid_out), 0);
    // backpressure
    step();
    en = 4'hF; ready_in = 4'h0; valid_in = 1'b1; data_in = 17'h00011;
    step();
    data_in = 17'h00022;
    step();
    data_in = 17'h00033;
    #1 chk("bp_full", 32'(ready_out), 0);
    chk("bp_head", 32'(data_out), 32'h11);
    step();
    ready_in = 4'hF;
    #1 chk("bp_c3_ready", 32'(ready_out), 0);
    step();
    #1 chk("bp_c4_ready", 32'(ready_out), 1);
    chk("bp_c4_head", 32'(data_out), 32'h22);
    step();
    valid_in = 1'b0;
    #1 chk("bp_c5_head", 32'(data_out), 32'h33);
    step();
    step();
    #1 chk("bp_empty", 32'(busy), 0);
    // throughput
    valid_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_in = 17'(32'h100 + k);
      if (k > 0) begin
        #1 chk("tp_data", 32'(data_out), 32'h100 + 32'(k - 1));
        chk("tp_valid", 32'(valid_out), 32'hF);
      end
      chk("tp_ready", 32'(ready_out), 1);
      step();
    end
    valid_in = 1'b0;
    #1 chk("tp_last", 32'(data_out), 32'h109);
    step();
    #1 chk("tp_busy", 32'(busy), 0);
    // mask change mid-word
    step();
    cfg_mask = 4'b0011; ready_in = 4'b0000; valid_in = 1'b1; data_in = 17'h0BEEF;
    step();
    valid_in = 1'b0; ready_in = 4'b0001;
    #1 chk("mk_c1", 32'(valid_out), 32'h3);
    step();
    ready_in = 4'b0000; en = 4'b1110;
    #1 chk("mk_c2", 32'(valid_out), 32'h2);
    step();
    en = 4'hF; ready_in = 4'b0001;
    #1 chk("mk_c3_nodup", 32'(valid_out), 32'h2);
    step();
    cfg_mask = 4'b0001;
    #1 chk("mk_c4_valid", 32'(valid_out), 0);
    chk("mk_c4_busy", 32'(busy), 1);
    step();
    #1 chk("mk_c5_busy", 32'(busy), 0);
    // reset mid-operation with a partially accepted head
    step();
    cfg_mask = 4'hF; ready_in = 4'h0; valid_in = 1'b1; data_in = 17'h0AAAA;
    step();
    data_in = 17'h05555;
    step();
    valid_in = 1'b0; ready_in = 4'b0001;
    step();
    ready_in = 4'b0000;
    #1 chk("rs_pre", 32'(valid_out), 32'hE);
    ASYNCRESET = 1'b1;
    #1 chk("rs_valid", 32'(valid_out), 0);
    chk("rs_busy", 32'(busy), 0);
    chk("rs_ready", 32'(ready_out), 1);
    step();
    ASYNCRESET = 1'b0; valid_in = 1'b1; data_in = 17'h0C0DE;
    step();
    valid_in = 1'b0;
    #1 chk("rs_fresh", 32'(valid_out), 32'hF);
    chk("rs_data", 32'(data_out), 32'hC0DE);
    ready_in = 4'hF;
    step();
    step();
    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      valid_in = ($urandom_range(3) != 0);
      data_in = 17'($urandom);
      ready_in = 4'($urandom);
      if ($urandom_range(15) == 0) en = 4'($urandom);
      if ($urandom_range(15) == 0) cfg_mask = 4'($urandom);
      step();
    end
    valid_in = 1'b0; en = 4'hF; cfg_mask = 4'hF; ready_in = 4'hF;
    step();
    step();
    step();
    #1 chk("end_busy", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fanout_broadcast_buffer.md
# fanout_broadcast_buffer

Registered ready/valid broadcast stage for the sparse-dataflow interconnect. Sits directly downstream of a track's producer and upstream of its NUM_OUT consumers. Replaces the all-ready AND gate at a fanout point with per-consumer acceptance tracking, so a slow consumer never blocks a transfer another consumer has already taken. One upstream word is held until every active consumer has accepted it exactly once.

## Interface

Parameters:
- NUM_OUT, 20, number of fanout destinations
- WIDTH, 17, data width (16-bit payload plus 1 control/token flag)

Ports (one clock; reset is asynchronous and active-high):
- CLK  input  1  clock, rising edge
- ASYNCRESET  input  1  asynchronous active-high reset
- data_in  input  WIDTH  upstream data
- valid_in  input  1  upstream valid
- ready_out  output  1  upstream ready
- en  input  NUM_OUT  per-destination enable (tile/route enable)
- cfg_mask  input  NUM_OUT  per-destination config select; quasi-static
- data_out  output  WIDTH  head word, shared by all destinations
- valid_out  output  NUM_OUT  per-destination valid
- ready_in  input  NUM_OUT  per-destination ready
- busy  output  1  high when the FIFO holds at least one word

## Operation

- active[i] = en[i] & cfg_mask[i]. An inactive destination never sees valid_out[i]=1 and never gates the upstream side.
- Storage: 2-entry FIFO (head/tail, count 0..2).
  - Push when valid_in & ready_out.
  - ready_out = (count != 2); no bypass.
- pending[NUM_OUT] register tracks which destinations still owe acceptance of the head word.
  - Set to all ones whenever a new word becomes head.
  - Bit i clears on valid_out[i] & ready_in[i].
- valid_out[i] = (count != 0) & active[i] & pending[i].
- data_out = head data. Its value is don't-care when count == 0.
- done_next[i] = ~active[i] | ~pending[i] | ready_in[i].
- Pop when (count != 0) & AND(done_next). The pop takes effect in the same cycle as the last outstanding acceptance.
- On pop, pending resets to all ones for the next head, or for an empty FIFO.
- No active destinations (all active == 0): each head pops one cycle after it becomes head. Words are discarded at one per cycle.
- Mask/enable change while a head is outstanding:
  - A newly inactive destination counts as done.
  - A re-activated destination with pending still set receives the word.
  - A re-activated destination whose pending is already cleared does not receive it again.
- busy = (count != 0).

## Timing

- Reset values (held while ASYNCRESET is high and after release): count = 0, pending = all ones, valid_out = 0, busy = 0, ready_out = 1. FIFO data contents are don't-care.
- Latency: a word pushed in cycle t is first visible on data_out/valid_out in cycle t+1.
- Throughput: one word per cycle when every active destination holds ready_in high.
- Simultaneous push and pop:
  - count 1: count stays 1; the pushed word becomes head at the next edge, with pending = all ones.
  - count 2: no push is possible (ready_out = 0).
- A destination accepts at most once per word. Holding ready_in[i] high after its acceptance has no effect.
- valid_out[i], once high, stays high with data_out stable until that destination accepts. The only exceptions are active[i] falling or reset.
- Reset asserted mid-transfer: the FIFO is flushed and partially delivered words are lost. The outputs take their reset values immediately (asynchronously).

## Structure

- Shared package: FANOUT_NUM_OUT_DEFAULT = 20 and FANOUT_WIDTH_DEFAULT = 17, plus a typedef for the fanout mask vector (logic [NUM_OUT-1:0]). The package is shared with the existing fanout-ready aggregation logic.
- Sub-module reg_fifo_d2: a generic 2-entry register FIFO (push, pop, data, count, full, empty) on CLK/ASYNCRESET.
- Top level contains pending tracking, the valid gating, and the pop decision.

## Test plan

- Basic broadcast: NUM_OUT=4, active=4'b1011, all ready_in=1, push 0x00A5 at cycle 0 -> valid_out=4'b1011 at cycle 1, pop at cycle 1, busy=0 at cycle 2.
- Staggered acceptance: active=4'b0111; ready_in pulses bit 0 at cycle 1, bit 2 at cycle 3, bit 1 at cycle 5. Expected:
  - each valid bit drops the cycle after its own accept;
  - pop at cycle 5;
  - no destination sees the word twice.
- Backpressure/full: all ready_in=0, push 3 words back-to-back -> ready_out=0 after the second push; the third word is held upstream; count=2.
- Throughput: all ready, valid_in held high for 10 words -> 10 words delivered in cycles 1-10, in order, with ready_out constantly 1.
- Mask change mid-word: active=4'b0011, bit 0 accepted, bit 1 stalled; clear cfg_mask[1] -> pop the same cycle; re-enabling bit 0 later causes no duplicate delivery.
- Reset mid-operation: count=2 with a partially accepted head, assert ASYNCRESET between clock edges -> valid_out=0, busy=0, ready_out=1 immediately; after release the first push delivers with fresh pending.
